seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a 4-digit common-anode 7-seg display.

---
 rtl/seg_scan_ctrl.sv | 102 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Steps through the four nibbles of the displayed value on a prescaled tick.
// New values are swapped in only at frame wrap, so a frame is never torn.
// Optionally blanks leading zeros.
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned DIV_W    = 16,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  hex,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam logic [DIV_W-1:0] CntMax = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic [1:0]       d;
  logic [15:0]      disp;
  logic [15:0]      pend;
  logic             pend_v;

  logic tick;
  logic boundary;
  logic blank;

  assign tick     = enable && (cnt == CntMax);
  assign boundary = tick && (d == 2'd3);

  // Leading-zero blanking: a digit is dark when it and every digit left of it are zero.
  always_comb begin
    blank = 1'b0;
    if (LZ_BLANK) begin
      unique case (d)
        2'd1:    blank = (disp[15:4] == 12'h000);
        2'd2:    blank = (disp[15:8] == 8'h00);
        2'd3:    blank = (disp[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
  end

  // Prescaler and digit index; both freeze while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      d   <= 2'd0;
    end else if (enable) begin
      if (tick) begin
        cnt <= '0;
        d   <= d + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Load handshake: pending value is promoted to the display only at frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp     <= 16'h0000;
      pend     <= 16'h0000;
      pend_v   <= 1'b0;
      load_ack <= 1'b0;
    end else if (boundary && load) begin
      // Bypass: the strobe on the wrap cycle wins over any older pending value.
      disp     <= value_in;
      pend_v   <= 1'b0;
      load_ack <= 1'b1;
    end else if (boundary && pend_v) begin
      disp     <= pend;
      pend_v   <= 1'b0;
      load_ack <= 1'b1;
    end else if (load) begin
      pend     <= value_in;
      pend_v   <= 1'b1;
      load_ack <= 1'b0;
    end else begin
      load_ack <= 1'b0;
    end
  end

  // Registered display outputs, one cycle behind the digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex         <= 4'h0;
      an          <= 4'b1111;
      frame_start <= 1'b0;
    end else begin
      hex         <= disp[{d, 2'b00} +: 4];
      an          <= (blank || !enable) ? 4'b1111 : ~(4'b0001 << d);
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4. Two instances share the
// stimulus: one without and one with leading-zero blanking.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value_in;

  logic        ack0, ack1, fs0, fs1;
  logic [3:0]  hex0, hex1, an0, an1;

  int unsigned n_checks  = 0;
  int unsigned n_pass    = 0;
  int unsigned multi_low = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(4), .DIV_W(16), .LZ_BLANK(1'b0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .value_in    (value_in),
    .load        (load),
    .load_ack    (ack0),
    .hex         (hex0),
    .an          (an0),
    .frame_start (fs0)
  );

  seg_scan_ctrl #(.CLK_DIV(4), .DIV_W(16), .LZ_BLANK(1'b1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .value_in    (value_in),
    .load        (load),
    .load_ack    (ack1),
    .hex         (hex1),
    .an          (an1),
    .frame_start (fs1)
  );

  typedef struct {
    int          ncyc;
    logic        ld;
    logic [15:0] val;
    logic        en;
    logic [3:0]  an0;
    logic [3:0]  an1;
    logic [3:0]  hex;
    logic        ack;
    logic        fs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input int n, input logic ld, input logic [15:0] val,
                             input logic en, input logic [3:0] a0, input logic [3:0] a1,
                             input logic [3:0] h, input logic ak, input logic f);
    vec_t r;
    r.ncyc = n; r.ld = ld; r.val = val; r.en = en;
    r.an0 = a0; r.an1 = a1; r.hex = h; r.ack = ak; r.fs = f;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if ($countones(~an0) > 1 || $countones(~an1) > 1) multi_low++;
  endtask

  initial begin
    // Edge counts in comments are relative to reset release (first free edge = 1).
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h0, 0, 0)); // 4: first tick
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1101, 4'b1111, 4'h0, 0, 0)); // 5
    tbl.push_back(v(11, 0, 16'h0000, 1, 4'b0111, 4'b1111, 4'h0, 0, 1)); // 16: no ack
    tbl.push_back(v( 3, 1, 16'h1234, 1, 4'b1110, 4'b1110, 4'h0, 0, 0)); // 19
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h0, 0, 0)); // 20
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1101, 4'b1111, 4'h0, 0, 0)); // 21
    tbl.push_back(v(11, 0, 16'h0000, 1, 4'b0111, 4'b1111, 4'h0, 1, 1)); // 32
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h4, 0, 0)); // 1234
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b1101, 4'b1101, 4'h3, 0, 0));
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b1011, 4'b1011, 4'h2, 0, 0));
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b0111, 4'b0111, 4'h1, 0, 0));
    tbl.push_back(v( 3, 0, 16'h0000, 1, 4'b0111, 4'b0111, 4'h1, 0, 1)); // 48: idle wrap
    tbl.push_back(v( 6, 1, 16'hABCD, 1, 4'b1101, 4'b1101, 4'h3, 0, 0)); // mid-frame load
    tbl.push_back(v(10, 0, 16'h0000, 1, 4'b0111, 4'b0111, 4'h1, 1, 1));
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'hD, 0, 0));
    tbl.push_back(v(12, 0, 16'h0000, 1, 4'b0111, 4'b0111, 4'hA, 0, 0));
    tbl.push_back(v( 3, 0, 16'h0000, 1, 4'b0111, 4'b0111, 4'hA, 0, 1));
    tbl.push_back(v( 5, 1, 16'h1111, 1, 4'b1101, 4'b1101, 4'hC, 0, 0)); // overwrite
    tbl.push_back(v(11, 1, 16'h2222, 1, 4'b0111, 4'b0111, 4'hA, 1, 1));
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h2, 0, 0));
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b1101, 4'b1101, 4'h2, 0, 0));
    tbl.push_back(v(10, 1, 16'h4444, 1, 4'b0111, 4'b0111, 4'h2, 0, 0)); // pending 4444
    tbl.push_back(v( 1, 1, 16'h3333, 1, 4'b0111, 4'b0111, 4'h2, 1, 1)); // bypass on wrap
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h3, 0, 0));
    tbl.push_back(v(15, 0, 16'h0000, 1, 4'b0111, 4'b0111, 4'h3, 0, 1)); // 4444 discarded
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h3, 0, 0));
    tbl.push_back(v( 1, 1, 16'h5555, 0, 4'b1111, 4'b1111, 4'h3, 0, 0)); // disabled
    tbl.push_back(v( 9, 0, 16'h0000, 0, 4'b1111, 4'b1111, 4'h3, 0, 0));
    tbl.push_back(v( 3, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h3, 0, 0)); // resume slot
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1101, 4'b1101, 4'h3, 0, 0));
    tbl.push_back(v(11, 0, 16'h0000, 1, 4'b0111, 4'b0111, 4'h3, 1, 1));
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h5, 0, 0));
    tbl.push_back(v(15, 1, 16'h0042, 1, 4'b0111, 4'b0111, 4'h5, 1, 1));
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h2, 0, 0)); // 0042
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b1101, 4'b1101, 4'h4, 0, 0));
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b1011, 4'b1111, 4'h0, 0, 0));
    tbl.push_back(v( 4, 1, 16'h0000, 1, 4'b0111, 4'b1111, 4'h0, 0, 0));
    tbl.push_back(v( 3, 0, 16'h0000, 1, 4'b0111, 4'b1111, 4'h0, 1, 1));
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h0, 0, 0)); // 0000
    tbl.push_back(v( 4, 1, 16'h1000, 1, 4'b1101, 4'b1111, 4'h0, 0, 0));
    tbl.push_back(v( 8, 0, 16'h0000, 1, 4'b0111, 4'b1111, 4'h0, 0, 0));
    tbl.push_back(v( 3, 0, 16'h0000, 1, 4'b0111, 4'b1111, 4'h0, 1, 1));
    tbl.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'b1110, 4'h0, 0, 0)); // 1000
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b1101, 4'b1101, 4'h0, 0, 0));
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b1011, 4'b1011, 4'h0, 0, 0));
    tbl.push_back(v( 4, 0, 16'h0000, 1, 4'b0111, 4'b0111, 4'h1, 0, 0));

    // Power-on reset.
    rst = 1'b1; enable = 1'b1; load = 1'b0; value_in = 16'h0000;
    step(); step();
    check("por_an0", {12'h0, an0}, 16'h000F);
    check("por_an1", {12'h0, an1}, 16'h000F);
    check("por_hex", {12'h0, hex0}, 16'h0000);
    check("por_ack", {14'h0, ack0, ack1}, 16'h0000);
    check("por_fs",  {14'h0, fs0, fs1}, 16'h0000);

    // Scan partway with a load pending, then reset for 3 cycles.
    rst = 1'b0; load = 1'b1; value_in = 16'hFFFF;
    step();
    load = 1'b0; value_in = 16'h0000;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d_an", i), {8'h0, an0, an1}, 16'h00FF);
      check($sformatf("rst%0d_hex", i), {8'h0, hex0, hex1}, 16'h0000);
      check($sformatf("rst%0d_ack", i), {14'h0, ack0, ack1}, 16'h0000);
    end
    rst = 1'b0;

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].ncyc; c++) begin
        load     = (c == 0) ? tbl[i].ld : 1'b0;
        value_in = tbl[i].val;
        enable   = tbl[i].en;
        step();
      end
      load = 1'b0;
      check($sformatf("v%0d_an0", i), {12'h0, an0}, {12'h0, tbl[i].an0});
      check($sformatf("v%0d_an1", i), {12'h0, an1}, {12'h0, tbl[i].an1});
      check($sformatf("v%0d_hex", i), {8'h0, hex0, hex1}, {8'h0, tbl[i].hex, tbl[i].hex});
      check($sformatf("v%0d_ack", i), {14'h0, ack0, ack1}, {14'h0, tbl[i].ack, tbl[i].ack});
      check($sformatf("v%0d_fs", i),  {14'h0, fs0, fs1}, {14'h0, tbl[i].fs, tbl[i].fs});
    end

    check("anode_onehot0", multi_low[15:0], 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
